hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/cpu_pkg.sv | 18 +
 rtl/load_use_detect.sv | 29 ++
 rtl/hazard_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the hazard control slice.
//   REG_AW      : register-file address width
//   NOP_INSTR   : canonical NOP (addi x0, x0, 0) used when ID/EX is bubbled
//   hz_state_e  : hazard controller FSM state encoding (also exported for debug)
package cpu_pkg;

  localparam int unsigned REG_AW = 5;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    StBoot    = 2'd0,
    StRun     = 2'd1,
    StFlush   = 2'd2,
    StWaitMem = 2'd3
  } hz_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector (purely combinational).
// Ports:
//   id_rs1, id_rs2         : source registers of the instruction in ID
//   id_use_rs1, id_use_rs2 : ID instruction really reads that source
//   ex_rd                  : destination register of the instruction in EX
//   ex_mem_read            : EX instruction is a load
//   load_use               : ID needs the load result that is not yet available
module load_use_detect #(
  parameter int unsigned REG_AW = cpu_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  output logic              load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: boot redirect, branch flush, load-use bubble,
// multicycle-EX stall and instruction-memory wait with a pending redirect.
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   boot_add                        : PC for the first fetch after reset
//   id_rs1/id_rs2/id_use_rs1/2      : ID source operands
//   ex_rd/ex_mem_read               : EX destination and load flag
//   ex_branch_taken/ex_branch_target: EX redirect request
//   ex_busy                         : multicycle EX unit still working
//   imem_ready                      : instruction memory data valid
//   stall/flush                     : fetch stage freeze / IF-ID kill
//   pc_sel/pc_dest                  : next-PC override and its value (0 when unused)
//   id_ex_bubble                    : insert NOP into ID/EX
//   stall_cnt                       : saturating count of stalled cycles
//   state_o                         : current FSM state
module hazard_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_AW     = cpu_pkg::REG_AW,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] boot_add,
  input  logic [REG_AW-1:0]     id_rs1,
  input  logic [REG_AW-1:0]     id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_AW-1:0]     ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic [DATA_WIDTH-1:0] ex_branch_target,
  input  logic                  ex_busy,
  input  logic                  imem_ready,
  output logic                  stall,
  output logic                  flush,
  output logic                  pc_sel,
  output logic [DATA_WIDTH-1:0] pc_dest,
  output logic                  id_ex_bubble,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [1:0]            state_o
);

  import cpu_pkg::*;

  hz_state_e             state_q, state_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [DATA_WIDTH-1:0] pend_target_q, pend_target_d;
  logic [CNT_W-1:0]      stall_cnt_q;
  logic                  load_use;

  load_use_detect #(
    .REG_AW (REG_AW)
  ) u_load_use_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    stall         = 1'b0;
    flush         = 1'b0;
    pc_sel        = 1'b0;
    pc_dest       = '0;
    id_ex_bubble  = 1'b0;

    unique case (state_q)
      StBoot: begin
        pc_sel  = 1'b1;
        pc_dest = boot_add;
        flush   = 1'b1;
        state_d = StRun;
      end

      StRun: begin
        // Only the highest-priority event acts; a branch makes any stall moot.
        if (ex_branch_taken) begin
          pc_sel       = 1'b1;
          pc_dest      = ex_branch_target;
          flush        = 1'b1;
          id_ex_bubble = 1'b1;
          state_d      = StFlush;
        end else if (load_use) begin
          stall        = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (ex_busy) begin
          stall = 1'b1;
        end else if (!imem_ready) begin
          stall   = 1'b1;
          state_d = StWaitMem;
        end
      end

      StFlush: begin
        // EX holds the bubble inserted by the redirect, so any branch flag is stale.
        flush   = 1'b1;
        state_d = StRun;
      end

      StWaitMem: begin
        if (!imem_ready) begin
          stall = 1'b1;
          if (ex_branch_taken) begin
            pend_valid_d  = 1'b1;
            pend_target_d = ex_branch_target;
          end
        end else if (ex_branch_taken || pend_valid_q) begin
          // A branch resolving on the exit cycle is the newest one and wins.
          pc_sel       = 1'b1;
          pc_dest      = ex_branch_taken ? ex_branch_target : pend_target_q;
          flush        = 1'b1;
          id_ex_bubble = 1'b1;
          pend_valid_d = 1'b0;
          state_d      = StFlush;
        end else begin
          state_d = StRun;
        end
      end

      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StBoot;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign state_o   = state_q;

endmodule
